// File: rtl/decoder_scan_seq.sv
// Registered binary-to-one-hot decoder with direct-select and dwell-timed scan modes.
// Build option: define DECODER_SCAN_ACTIVE_LOW_EN to drive D active-low.
module decoder_scan_seq #(
  parameter int SEL_W = 4,
  parameter int OUT_W = 16,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sel_vld,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             stop,
  output logic [OUT_W-1:0] D,
  output logic [SEL_W-1:0] idx,
  output logic             busy,
  output logic             wrap,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int               CNT_W    = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]   OUT_W_L  = (SEL_W + 1)'(OUT_W);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] D_IDLE = '1;
`else
  localparam logic [OUT_W-1:0] D_IDLE = '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_dwell, w_dwell_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             r_err, w_err_nxt;
  logic [OUT_W-1:0] r_d, w_d_nxt, w_onehot;

  // State register: every architectural register, including D, updates here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_dwell <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_d     <= D_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_dwell <= w_dwell_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
      r_d     <= w_d_nxt;
    end
  end

  // Next-state: command priority stop > start(mode=1) > sel_vld(mode=0); en=0 freezes all.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dwell_nxt = r_dwell;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (en) begin
      if (stop) begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_dwell_nxt = '0;
      end else if (start && mode) begin
        w_state_nxt = ST_SCAN;
        w_idx_nxt   = '0;
        w_dwell_nxt = DWELL_M1;
      end else if (sel_vld && !mode) begin
        w_dwell_nxt = '0;
        if ({1'b0, sel} < OUT_W_L) begin
          w_state_nxt = ST_HOLD;
          w_idx_nxt   = sel;
        end else begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_err_nxt   = 1'b1;
        end
      end else if (r_state == ST_SCAN) begin
        if (r_dwell == '0) begin
          w_dwell_nxt = DWELL_M1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_dwell_nxt = r_dwell - 1'b1;
        end
      end
    end
  end

  // Outputs: D is precomputed here and registered, so the pins never glitch.
  always_comb begin
    w_onehot = '0;
    if (en && (w_state_nxt != ST_IDLE)) begin
      w_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << w_idx_nxt;
    end
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    w_d_nxt   = ~w_onehot;
`else
    w_d_nxt   = w_onehot;
`endif
    D         = r_d;
    idx       = r_idx;
    busy      = (r_state == ST_SCAN);
    wrap      = r_wrap;
    err       = r_err;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq (SEL_W=4, OUT_W=10, DWELL=3); honours DECODER_SCAN_ACTIVE_LOW_EN.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst, en, mode, sel_vld, start, stop;
  logic [3:0] sel;
  logic [9:0] D;
  logic [3:0] idx;
  logic       busy, wrap, err;
  logic [1:0] dbg_state;
  int         n_cmp  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  decoder_scan_seq #(.SEL_W(4), .OUT_W(10), .DWELL(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_vld(sel_vld), .sel(sel),
    .start(start), .stop(stop), .D(D), .idx(idx), .busy(busy), .wrap(wrap),
    .err(err), .dbg_state(dbg_state)
  );

  function automatic logic [9:0] exp_d(input logic [9:0] oh);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    return ~oh;
`else
    return oh;
`endif
  endfunction

  // Inputs are applied, then one edge passes, then outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    sel_vld = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 4'd0; clear_cmds();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (D !== exp_d(10'h000)) begin n_fail++; $display("FAIL reset_D got=%h exp=%h", D, exp_d(10'h000)); end
    n_cmp++; if (idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    n_cmp++; if ({busy, wrap, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy, wrap, err}); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_direct();
    mode = 1'b0; sel_vld = 1'b1; sel = 4'd9;
    tick();
    clear_cmds();
    n_cmp++; if (D !== exp_d(10'h200)) begin n_fail++; $display("FAIL direct_D got=%h exp=%h", D, exp_d(10'h200)); end
    n_cmp++; if (idx !== 4'd9) begin n_fail++; $display("FAIL direct_idx got=%0d exp=9", idx); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL direct_state got=%0d exp=1", dbg_state); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (D !== exp_d(10'h200) || busy !== 1'b0) begin n_fail++; $display("FAIL direct_hold cyc=%0d D=%h busy=%b exp=%h/0", i, D, busy, exp_d(10'h200)); end
    end
    // sel_vld with mode=1 and start with mode=0 are both ignored
    sel_vld = 1'b1; mode = 1'b1; sel = 4'd5;
    tick();
    sel_vld = 1'b0; start = 1'b1; mode = 1'b0;
    tick();
    clear_cmds();
    n_cmp++; if (D !== exp_d(10'h200) || idx !== 4'd9 || busy !== 1'b0) begin n_fail++; $display("FAIL ignored_cmds D=%h idx=%0d busy=%b exp=%h/9/0", D, idx, busy, exp_d(10'h200)); end
  endtask

  task automatic test_out_of_range();
    mode = 1'b0; sel_vld = 1'b1; sel = 4'd12;
    tick();
    clear_cmds();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", err); end
    n_cmp++; if (D !== exp_d(10'h000) || idx !== 4'd0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL oor_out D=%h idx=%0d st=%0d exp=%h/0/0", D, idx, dbg_state, exp_d(10'h000)); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse got=%b exp=0", err); end
    // sel = OUT_W is the first illegal code
    sel_vld = 1'b1; sel = 4'd10;
    tick();
    n_cmp++; if (err !== 1'b1 || D !== exp_d(10'h000)) begin n_fail++; $display("FAIL oor_edge err=%b D=%h exp=1/%h", err, D, exp_d(10'h000)); end
    sel = 4'd3;
    tick();
    clear_cmds();
    n_cmp++; if (D !== exp_d(10'h008) || idx !== 4'd3 || err !== 1'b0) begin n_fail++; $display("FAIL oor_recover D=%h idx=%0d err=%b exp=%h/3/0", D, idx, err, exp_d(10'h008)); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [4];
    logic [9:0] ohs   [4];
    logic [3:0] idxs  [4];
    logic       errs  [4];
    codes = '{4'd1, 4'd7, 4'd15, 4'd0};
    ohs   = '{10'h002, 10'h080, 10'h000, 10'h001};
    idxs  = '{4'd1, 4'd7, 4'd0, 4'd0};
    errs  = '{1'b0, 1'b0, 1'b1, 1'b0};
    mode = 1'b0; sel_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = codes[i];
      tick();
      n_cmp++; if (D !== exp_d(ohs[i]) || idx !== idxs[i] || err !== errs[i]) begin n_fail++; $display("FAIL b2b_%0d D=%h idx=%0d err=%b exp=%h/%0d/%b", i, D, idx, err, exp_d(ohs[i]), idxs[i], errs[i]); end
    end
    clear_cmds();
  endtask

  task automatic test_scan();
    logic [9:0] oh;
    mode = 1'b1; start = 1'b1;
    tick();
    clear_cmds();
    for (int k = 0; k <= 31; k++) begin
      if (k > 0) tick();
      oh = 10'd1 << ((k / 3) % 10);
      n_cmp++; if (D !== exp_d(oh) || idx !== 4'((k / 3) % 10) || busy !== 1'b1 || wrap !== (k == 30)) begin
        n_fail++; $display("FAIL scan_k%0d D=%h idx=%0d busy=%b wrap=%b exp=%h/%0d/1/%b", k, D, idx, busy, wrap, exp_d(oh), (k / 3) % 10, (k == 30));
      end
    end
  endtask

  task automatic test_freeze();
    mode = 1'b1; start = 1'b1;
    tick();                       // idx 0, first dwell cycle
    clear_cmds();
    tick();                       // idx 0, second dwell cycle
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin sel_vld = 1'b1; mode = 1'b0; sel = 4'd5; end
      if (i == 2) begin clear_cmds(); mode = 1'b1; end
      tick();
      n_cmp++; if (D !== exp_d(10'h000) || idx !== 4'd0 || busy !== 1'b1 || wrap !== 1'b0) begin n_fail++; $display("FAIL freeze_%0d D=%h idx=%0d busy=%b exp=%h/0/1", i, D, idx, busy, exp_d(10'h000)); end
    end
    en = 1'b1;
    tick();                       // remaining third dwell cycle of idx 0
    n_cmp++; if (D !== exp_d(10'h001) || idx !== 4'd0) begin n_fail++; $display("FAIL resume_rem D=%h idx=%0d exp=%h/0", D, idx, exp_d(10'h001)); end
    tick();
    n_cmp++; if (D !== exp_d(10'h002) || idx !== 4'd1) begin n_fail++; $display("FAIL resume_adv D=%h idx=%0d exp=%h/1", D, idx, exp_d(10'h002)); end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) tick(); // idx 2 now
    mode = 1'b1; start = 1'b1;
    tick();
    clear_cmds();
    n_cmp++; if (D !== exp_d(10'h001) || idx !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart D=%h idx=%0d busy=%b exp=%h/0/1", D, idx, busy, exp_d(10'h001)); end
    start = 1'b1; stop = 1'b1;
    tick();
    clear_cmds();
    n_cmp++; if (D !== exp_d(10'h000) || idx !== 4'd0 || busy !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL start_stop D=%h idx=%0d busy=%b st=%0d exp=%h/0/0/0", D, idx, busy, dbg_state, exp_d(10'h000)); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (D !== exp_d(10'h000) || dbg_state !== 2'd0 || err !== 1'b0) begin n_fail++; $display("FAIL stop_idle D=%h st=%0d err=%b exp=%h/0/0", D, dbg_state, err, exp_d(10'h000)); end
    mode = 1'b0; sel_vld = 1'b1; sel = 4'd6; stop = 1'b1;
    tick();
    clear_cmds();
    n_cmp++; if (D !== exp_d(10'h000) || idx !== 4'd0) begin n_fail++; $display("FAIL stop_over_sel D=%h idx=%0d exp=%h/0", D, idx, exp_d(10'h000)); end
  endtask

  task automatic test_rst_mid_scan();
    mode = 1'b1; start = 1'b1;
    tick();
    clear_cmds();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; start = 1'b1; sel_vld = 1'b1;
    tick();
    rst = 1'b0; clear_cmds();
    n_cmp++; if (D !== exp_d(10'h000) || idx !== 4'd0 || {busy, wrap, err} !== 3'b000 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid D=%h idx=%0d flags=%b st=%0d exp=%h/0/000/0", D, idx, {busy, wrap, err}, dbg_state, exp_d(10'h000));
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_out_of_range();
    test_back_to_back();
    test_scan();
    test_freeze();
    test_priority();
    test_rst_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder with two modes: direct select and automatic timed scan.
- Intended for row/digit select in memory-array and display-multiplex designs.
- Sits between a controller or counter and a bank of one-hot enable lines.
- Generalises the fixed 4-to-16 tree decoder in width and output count, and adds a dwell-timed scan sequencer, wrap and error flags.

Parameters:
- SEL_W, 4, select code width in bits.
- OUT_W, 16, number of one-hot outputs; legal range 2..2**SEL_W.
- DWELL, 4, clock cycles each output stays asserted in scan mode; must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  output enable; when low, D is driven to all-inactive and the state, index and dwell counter freeze.
- mode  input  1  0 = direct, 1 = scan; sampled only when a command is accepted.
- sel_vld  input  1  direct-mode load strobe.
- sel  input  SEL_W  direct-mode select code.
- start  input  1  scan start strobe.
- stop  input  1  return to IDLE.
- D  output  OUT_W  registered one-hot select lines.
- idx  output  SEL_W  currently active index; 0 in IDLE.
- busy  output  1  high in the SCAN state.
- wrap  output  1  one-cycle pulse when the scan advances from OUT_W-1 to 0.
- err  output  1  one-cycle pulse on an out-of-range sel.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE, D = all-inactive, idx = 0, busy = 0, wrap = 0, err = 0, dwell counter = 0.
  - rst overrides every other input and takes effect mid-scan.
- States: IDLE, HOLD, SCAN.
  - IDLE: D inactive.
  - HOLD: D = onehot(idx), static.
  - SCAN: D = onehot(idx), idx advancing.
- Command priority, evaluated each cycle with en=1: stop > start (mode=1) > sel_vld (mode=0).
  - sel_vld with mode=1, or start with mode=0, is ignored.
- Direct load, from any state:
  - sel_vld=1, mode=0, sel < OUT_W → next cycle: state = HOLD, idx = sel, D = onehot(sel).
  - Latency is 1 clock.
- Out-of-range load: sel_vld=1, mode=0, sel >= OUT_W → next cycle: state = IDLE, D inactive, idx = 0, err = 1 for one cycle.
- Scan start, from any state:
  - start=1, mode=1 → next cycle: state = SCAN, idx = 0, D = onehot(0), busy = 1, dwell counter = DWELL-1.
  - A start while already in SCAN restarts the scan at idx 0.
- Scan advance:
  - In SCAN, the dwell counter decrements each enabled cycle.
  - When it reaches 0 it reloads DWELL-1 and idx advances on the next edge.
  - Each index is therefore active for exactly DWELL enabled cycles.
  - DWELL=1 advances every cycle.
- Wrap:
  - Advance from idx = OUT_W-1 sets idx = 0.
  - wrap = 1 in the same cycle D first shows onehot(0), for one cycle.
  - Scanning continues until stop.
- Stop: next cycle state = IDLE, D inactive, idx = 0, busy = 0. A stop in IDLE is harmless.
- en=0:
  - Next-cycle D is inactive.
  - No commands are accepted.
  - The dwell counter, idx and state hold; wrap and err stay 0.
  - When en returns to 1, D = onehot(idx) on the next cycle (HOLD/SCAN) and the remaining dwell count resumes.
- D always has at most one active bit. No glitch is allowed: D is taken directly from a register.
- Widths: idx advances modulo OUT_W, not 2**SEL_W. The dwell counter is clog2(DWELL)+1 bits wide.

Optional Feature:
- Macro: DECODER_SCAN_ACTIVE_LOW_EN.
- Defined:
  - D is active-low: the selected bit is 0 and all others are 1.
  - The reset, IDLE and en=0 value of D is all ones. Used for common-anode display digit drive.
- Undefined:
  - D is active-high: the selected bit is 1.
  - The reset, IDLE and en=0 value of D is all zeros.
- No other output changes polarity.

Test Plan:
- Reset, then idle 5 cycles → D = 0, idx = 0, busy = 0, wrap = 0, err = 0.
- Direct load: sel_vld=1, mode=0, sel=4'd9 (defaults) → next cycle D = 16'h0200, idx = 9, state HOLD; D holds for 10 idle cycles.
- Out-of-range: OUT_W=10, SEL_W=4, sel=4'd12 → err pulses 1 cycle, D = 0, idx = 0. Then sel=4'd3 → D = 10'h008.
- Scan sweep: OUT_W=4, DWELL=3, start with mode=1 → D follows 0001,0001,0001,0010 ×3,0100 ×3,1000 ×3, then 0001 with wrap=1 for 1 cycle; busy = 1 throughout.
- Freeze and priority:
  - In SCAN, drop en for 4 cycles mid-dwell → D = 0, idx held; after re-enable the remaining dwell completes.
  - Assert start and stop together → IDLE.
  - Assert rst mid-scan → all outputs at reset values next cycle.
- Macro build with DECODER_SCAN_ACTIVE_LOW_EN → after reset D = 16'hFFFF; sel=4'd0 gives D = 16'hFFFE.
